// File: rtl/nonce_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmit channel among hash cores.
// The granted nonce is latched and sent MSB first over the wr_en/tx_busy handshake.
module nonce_tx_scheduler #(
    parameter int NUM_CORES    = 4,
    parameter int NONCE_WIDTH  = 32,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             req,
    input  logic [NUM_CORES*NONCE_WIDTH-1:0] nonce_in,
    output logic [NUM_CORES-1:0]             ack,
    output logic [7:0]                       tx_data,
    output logic                             tx_wr_en,
    input  logic                             tx_busy,
    output logic                             busy,
    output logic [31:0]                      sent_count,
    output logic [15:0]                      retry_count
);

    localparam int NB = NONCE_WIDTH / 8;
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        STROBE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t                 state;
    logic [IW-1:0]          rr_ptr;
    logic [BW-1:0]          byte_idx;
    logic [NONCE_WIDTH-1:0] shift_reg;
    logic [NONCE_WIDTH-1:0] shifted;
    logic [TW-1:0]          tmo_cnt;

    logic                   found;
    logic [IW-1:0]          grant_idx;
    logic [IW-1:0]          next_rr;
    logic [NONCE_WIDTH-1:0] grant_nonce;
    int                     j;

    assign busy    = (state != IDLE);
    assign shifted = shift_reg << 8;
    assign next_rr = (grant_idx == IW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

    // Pick the first requesting core at or above the rr pointer, wrapping.
    always_comb begin
        found       = 1'b0;
        grant_idx   = '0;
        grant_nonce = '0;
        j           = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            if (!found && req[j]) begin
                found       = 1'b1;
                grant_idx   = IW'(j);
                grant_nonce = nonce_in[j*NONCE_WIDTH +: NONCE_WIDTH];
            end
        end
    end

    // Grant / byte sequencing FSM with registered strobe, ack and data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ack         <= '0;
            tx_wr_en    <= 1'b0;
            tx_data     <= '0;
            sent_count  <= '0;
            retry_count <= '0;
            rr_ptr      <= '0;
            byte_idx    <= '0;
            shift_reg   <= '0;
            tmo_cnt     <= '0;
        end else begin
            ack      <= '0;
            tx_wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        shift_reg <= grant_nonce;
                        ack       <= NUM_CORES'(1) << grant_idx;
                        rr_ptr    <= next_rr;
                        byte_idx  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    tx_data <= shift_reg[NONCE_WIDTH-1 -: 8];
                    state   <= STROBE;
                end
                STROBE: begin
                    tx_wr_en <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                        if (retry_count != 16'hFFFF)
                            retry_count <= retry_count + 16'd1;
                        state <= STROBE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (byte_idx == BW'(NB - 1)) begin
                            sent_count <= sent_count + 32'd1;
                            state      <= IDLE;
                        end else begin
                            shift_reg <= shifted;
                            byte_idx  <= byte_idx + 1'b1;
                            tx_data   <= shifted[NONCE_WIDTH-1 -: 8];
                            state     <= STROBE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_tx_scheduler.sv
// Directed bench for nonce_tx_scheduler with a UART busy model
// and byte/grant scoreboards filled at stimulus time.
module tb_nonce_tx_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] nonce_in;
    logic [3:0]   ack;
    logic [7:0]   tx_data;
    logic         tx_wr_en;
    logic         tx_busy;
    logic         busy;
    logic [31:0]  sent_count;
    logic [15:0]  retry_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int busy_len = 20;
    int byte_pos = 0;
    bit ignore_arm = 1'b0;
    int wr_total = 0;
    int ack_total = 0;
    int ack_cnt[4];
    int sat_base[4];
    int ack_cyc = 0;
    int fall_cyc = 0;
    int g = 0;
    int n = 0;
    int base = 0;
    logic        prev_wr = 1'b0;
    logic [31:0] sent_at_ack = '0;
    logic [3:0]  auto_drop = 4'hF;
    logic [7:0]  byte_q[$];
    int          grant_q[$];

    nonce_tx_scheduler #(
        .NUM_CORES(4),
        .NONCE_WIDTH(32),
        .BUSY_TIMEOUT(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .nonce_in(nonce_in),
        .ack(ack),
        .tx_data(tx_data),
        .tx_wr_en(tx_wr_en),
        .tx_busy(tx_busy),
        .busy(busy),
        .sent_count(sent_count),
        .retry_count(retry_count)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_nonce(input int core, input logic [31:0] v);
        nonce_in[core*32 +: 32] = v;
    endtask

    task automatic push_nonce(input int core, input logic [31:0] v);
        grant_q.push_back(core);
        for (int b = 0; b < 4; b++)
            byte_q.push_back(v[31-8*b -: 8]);
    endtask

    // One clock: UART model, byte scoreboard and ack scoreboard.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (!reset) begin
            busy_cnt = 0;
            tx_busy  = 1'b0;
            byte_pos = 0;
            prev_wr  = 1'b0;
            byte_q.delete();
        end else begin
            if (tx_wr_en) chk("wr_single_cycle", prev_wr, 0);
            prev_wr = tx_wr_en;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy  = 1'b0;
                    fall_cyc = cyc;
                end
            end else if (tx_wr_en) begin
                wr_total++;
                chk("byte_expected", byte_q.size() > 0, 1);
                if (byte_q.size() > 0) chk("tx_data", tx_data, byte_q[0]);
                if (ignore_arm && byte_pos == 2) begin
                    ignore_arm = 1'b0;
                end else begin
                    if (byte_q.size() > 0) void'(byte_q.pop_front());
                    byte_pos = (byte_pos + 1) % 4;
                    tx_busy  = 1'b1;
                    busy_cnt = busy_len;
                end
            end
            if (ack != 4'b0) begin
                ack_total++;
                ack_cyc     = cyc;
                sent_at_ack = sent_count;
                if (grant_q.size() == 0) begin
                    chk("ack_unexpected", ack, 0);
                end else begin
                    g = grant_q.pop_front();
                    chk("ack_grant", ack, 32'd1 << g);
                end
                for (int i = 0; i < 4; i++)
                    if (ack[i]) begin
                        ack_cnt[i]++;
                        if (auto_drop[i]) req[i] = 1'b0;
                    end
            end
        end
    endtask

    task automatic wait_sent(input logic [31:0] target);
        n = 0;
        while (sent_count !== target && n < 4000) begin
            tick();
            n++;
        end
        chk("sent_count", sent_count, target);
    endtask

    task automatic wait_acks(input int target);
        n = 0;
        while (ack_total < target && n < 4000) begin
            tick();
            n++;
        end
        chk("ack_total", ack_total, target);
    endtask

    initial begin
        reset    = 1'b0;
        req      = '0;
        nonce_in = '0;
        tx_busy  = 1'b0;
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_wr", tx_wr_en, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_retry", retry_count, 0);
        reset = 1'b1;
        tick();

        // single request, latency and byte order
        set_nonce(2, 32'hDEADBEEF);
        push_nonce(2, 32'hDEADBEEF);
        req[2] = 1'b1;
        tick();
        chk("t1_ack", ack, 4'b0100);
        tick();
        chk("t1_ack_once", ack, 0);
        chk("t1_wr_early", tx_wr_en, 0);
        tick();
        chk("t1_wr_lat", tx_wr_en, 1);
        wait_sent(1);
        chk("t1_busy_fall", busy, 0);
        chk("t1_strobes", wr_total, 4);
        chk("t1_bytes_left", byte_q.size(), 0);

        // round robin from rr=0
        reset = 1'b0;
        tick();
        tick();
        chk("t2_rst_sent", sent_count, 0);
        reset = 1'b1;
        set_nonce(0, 32'h00112233);
        set_nonce(1, 32'h44556677);
        set_nonce(3, 32'h8899AABB);
        push_nonce(0, 32'h00112233);
        push_nonce(1, 32'h44556677);
        push_nonce(3, 32'h8899AABB);
        req = 4'b1011;
        wait_sent(3);
        set_nonce(0, 32'hA0A1A2A3);
        set_nonce(3, 32'hB0B1B2B3);
        push_nonce(0, 32'hA0A1A2A3);
        push_nonce(3, 32'hB0B1B2B3);
        req = 4'b1001;
        wait_sent(5);
        chk("t2_grants_left", grant_q.size(), 0);

        // saturation fairness
        for (int i = 0; i < 4; i++) sat_base[i] = ack_cnt[i];
        base = ack_total;
        for (int i = 0; i < 4; i++) set_nonce(i, 32'h10203040 + i);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                push_nonce(i, 32'h10203040 + i);
        auto_drop = 4'h0;
        req = 4'hF;
        wait_acks(base + 12);
        req = 4'h0;
        auto_drop = 4'hF;
        wait_sent(17);
        for (int i = 0; i < 4; i++)
            chk("t3_fair", ack_cnt[i] - sat_base[i], 3);

        // busy timeout on the third byte
        ignore_arm = 1'b1;
        base = wr_total;
        set_nonce(1, 32'h0A1B2C3D);
        push_nonce(1, 32'h0A1B2C3D);
        req[1] = 1'b1;
        wait_sent(18);
        chk("t4_retry", retry_count, 1);
        chk("t4_strobes", wr_total - base, 5);
        chk("t4_ignored", ignore_arm, 0);
        chk("t4_bytes_left", byte_q.size(), 0);

        // reset while waiting for busy low of byte 1
        auto_drop[2] = 1'b0;
        set_nonce(2, 32'h11223344);
        push_nonce(2, 32'h11223344);
        req[2] = 1'b1;
        n = 0;
        while (byte_pos != 2 && n < 2000) begin
            tick();
            n++;
        end
        chk("t5_reached", byte_pos, 2);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("t5_wr", tx_wr_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_sent", sent_count, 0);
        chk("t5_retry", retry_count, 0);
        chk("t5_data", tx_data, 0);
        tick();
        tick();
        reset = 1'b1;
        push_nonce(2, 32'h11223344);
        auto_drop[2] = 1'b1;
        base = ack_total;
        wait_sent(1);
        chk("t5_regrant", ack_total - base, 1);
        chk("t5_bytes_left", byte_q.size(), 0);

        // request dropped before it can be sampled
        base = ack_total;
        tick();
        req[0] = 1'b1;
        #1;
        req[0] = 1'b0;
        repeat (5) tick();
        chk("t6_no_ack", ack_total, base);
        chk("t6_idle", busy, 0);

        // back-to-back request from core 1
        base = ack_total;
        set_nonce(1, 32'hCAFEF00D);
        push_nonce(1, 32'hCAFEF00D);
        req[1] = 1'b1;
        wait_acks(base + 1);
        tick();
        set_nonce(1, 32'h13579BDF);
        push_nonce(1, 32'h13579BDF);
        req[1] = 1'b1;
        wait_acks(base + 2);
        chk("t7_gap", ack_cyc - fall_cyc, 2);
        chk("t7_sent_at_ack", sent_at_ack, 2);
        wait_sent(3);
        chk("t7_bytes_left", byte_q.size(), 0);
        chk("t7_grants_left", grant_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
